// File: rtl/mips32_regfile_sb.sv
// mips32_regfile_sb
//   Register bank with a write scoreboard for the pipelined MIPS32 core.
//   ID reads two sources combinationally and is held off by iss_ready while
//   any source still has an outstanding write. WB retires writes in program
//   order. A writeback in the same cycle is forwarded to the read ports, so a
//   source whose last pending write lands this cycle does not stall.
//
//   Build option: REGFILE_INIT_INDEX_EN
//     When defined, reset loads reg[k] = k for k >= 1. Otherwise all
//     registers reset to zero. The scoreboard is the same in both builds.
//
// Ports
//   clk1, rst                 clock, asynchronous active-high reset
//   iss_valid/rs/rt/rd/wen    issue request from ID
//   iss_ready                 issue may proceed (independent of iss_valid)
//   rs_data, rt_data          source operands, bypassed from WB
//   wb_valid/rd/data          writeback from WB
//   flush                     taken branch: drop every pending write
//   pend_any                  some register has an outstanding write
//   err_wb                    sticky: a writeback found nothing pending

// One register plus its pending-write counter.
module mips32_regfile_sb_cell #(
  parameter int              XLEN   = 32,
  parameter int              CW     = 2,
  parameter logic [XLEN-1:0] RSTVAL = '0
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic            flush,
  input  logic            inc,
  input  logic            dec,
  input  logic            wr,
  input  logic [XLEN-1:0] wdata,
  output logic [CW-1:0]   pend,
  output logic [XLEN-1:0] q
);
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      pend <= '0;
      q    <= RSTVAL;
    end else begin
      // Flushing blocks issue, so inc is never set together with flush.
      if (flush)          pend <= '0;
      else if (inc && !dec) pend <= pend + CW'(1);
      else if (dec && !inc) pend <= pend - CW'(1);
      if (wr) q <= wdata;
    end
  end
endmodule

module mips32_regfile_sb #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int MAXPEND = 3
) (
  input  logic                    clk1,
  input  logic                    rst,
  input  logic                    iss_valid,
  input  logic [$clog2(NREG)-1:0] iss_rs,
  input  logic [$clog2(NREG)-1:0] iss_rt,
  input  logic [$clog2(NREG)-1:0] iss_rd,
  input  logic                    iss_wen,
  output logic                    iss_ready,
  output logic [XLEN-1:0]         rs_data,
  output logic [XLEN-1:0]         rt_data,
  input  logic                    wb_valid,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    flush,
  output logic                    pend_any,
  output logic                    err_wb
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(MAXPEND + 1);

  logic [NREG-1:0][CW-1:0]   pend;
  logic [NREG-1:0][XLEN-1:0] regs;
  logic                      src_busy_rs, src_busy_rt, cap_haz, issue;

  // R0: no storage, never pending.
  assign pend[0] = '0;
  assign regs[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
`ifdef REGFILE_INIT_INDEX_EN
    localparam logic [XLEN-1:0] RV = XLEN'(r);
`else
    localparam logic [XLEN-1:0] RV = '0;
`endif
    logic hit_wb;
    assign hit_wb = wb_valid && (wb_rd == AW'(r));

    mips32_regfile_sb_cell #(.XLEN(XLEN), .CW(CW), .RSTVAL(RV)) u_cell (
      .clk1  (clk1),
      .rst   (rst),
      .flush (flush),
      .inc   (issue && iss_wen && (iss_rd == AW'(r))),
      .dec   (hit_wb && (pend[r] != '0)),
      .wr    (hit_wb),
      .wdata (wb_data),
      .pend  (pend[r]),
      .q     (regs[r])
    );
  end

  // A source is busy unless its only outstanding write is retiring right now.
  function automatic logic src_busy(input logic [AW-1:0] s);
    return (s != '0) && (pend[s] != '0) &&
           !(wb_valid && (wb_rd == s) && (pend[s] == CW'(1)));
  endfunction

  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] s);
    if (s == '0)                    return '0;
    else if (wb_valid && wb_rd == s) return wb_data;
    else                            return regs[s];
  endfunction

  always_comb begin
    src_busy_rs = src_busy(iss_rs);
    src_busy_rt = src_busy(iss_rt);
    // Deliberately ignores a same-cycle writeback to iss_rd.
    cap_haz     = iss_wen && (iss_rd != '0) && (pend[iss_rd] == CW'(MAXPEND));
    iss_ready   = !flush && !src_busy_rs && !src_busy_rt && !cap_haz;
    issue       = iss_valid && iss_ready;
    rs_data     = rd_port(iss_rs);
    rt_data     = rd_port(iss_rt);
  end

  always_comb begin
    pend_any = 1'b0;
    for (int r = 0; r < NREG; r++) pend_any = pend_any | (pend[r] != '0);
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) err_wb <= 1'b0;
    else if (wb_valid && wb_rd != '0 && pend[wb_rd] == '0 && !flush) err_wb <= 1'b1;
  end
endmodule

// File: tb/tb_mips32_regfile_sb.sv
module tb_mips32_regfile_sb;
  logic        clk1 = 1'b0;
  logic        rst;
  logic        iss_valid, iss_wen, iss_ready;
  logic [4:0]  iss_rs, iss_rt, iss_rd, wb_rd;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_valid, flush, pend_any, err_wb;

  int checks = 0;
  int errors = 0;

  mips32_regfile_sb dut (
    .clk1(clk1), .rst(rst),
    .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd),
    .iss_wen(iss_wen), .iss_ready(iss_ready), .rs_data(rs_data), .rt_data(rt_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .pend_any(pend_any), .err_wb(err_wb)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] init_val(input int k);
`ifdef REGFILE_INIT_INDEX_EN
    return 32'(k);
`else
    return 32'(k) & 32'h0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_wen = 0; iss_rs = 0; iss_rt = 0; iss_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk1); #1;
    idle();
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    iss_valid = 1; iss_wen = 1; iss_rd = rd;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk1);
    #1 rst = 0;

    // Reset state
    iss_rs = 5; iss_rt = 30; #1;
    chk("rst_rs5", rs_data, init_val(5));
    chk("rst_rt30", rt_data, init_val(30));
    chk("rst_pend_any", pend_any, 0);
    chk("rst_err_wb", err_wb, 0);
    chk("rst_ready", iss_ready, 1);
    step();

    // RAW stall on R1
    issue_wr(1); #1;
    chk("raw_issue_ready", iss_ready, 1);
    step();
    iss_valid = 1; iss_rs = 1; iss_rt = 2; #1;
    chk("raw_stall0", iss_ready, 0);
    chk("raw_pend_any", pend_any, 1);
    step();
    iss_valid = 1; iss_rs = 1; iss_rt = 2; #1;
    chk("raw_stall1", iss_ready, 0);
    step();
    iss_valid = 1; iss_rs = 1; iss_rt = 2; wb(1, 10); #1;
    chk("raw_bypass_ready", iss_ready, 1);
    chk("raw_bypass_rs", rs_data, 10);
    chk("raw_rt", rt_data, init_val(2));
    step();
    iss_rs = 1; #1;
    chk("raw_pend_clear", pend_any, 0);
    chk("raw_array_rs", rs_data, 10);
    step();

    // WAW capacity on R4
    for (int i = 0; i < 3; i++) begin
      issue_wr(4); #1;
      chk("waw_issue_ready", iss_ready, 1);
      step();
    end
    issue_wr(4); wb(4, 20); #1;
    chk("waw_cap_stall", iss_ready, 0);
    step();
    wb(4, 25); step();
    wb(4, 30); step();
    iss_rs = 4; #1;
    chk("waw_reg4", rs_data, 30);
    chk("waw_pend_any", pend_any, 0);
    chk("waw_err_wb", err_wb, 0);
    step();

    // Simultaneous issue and writeback on R7
    issue_wr(7); step();
    issue_wr(7); wb(7, 77); #1;
    chk("r7_ready", iss_ready, 1);
    step();
    iss_rs = 7; #1;
    chk("r7_pend_kept", pend_any, 1);
    chk("r7_data", rs_data, 77);
    step();
    wb(7, 78); step();
    chk("r7_drained", pend_any, 0);
    chk("r7_err_wb", err_wb, 0);

    // R0 handling
    issue_wr(0); step();
    chk("r0_pend_any", pend_any, 0);
    wb(0, 55); iss_rs = 0; #1;
    chk("r0_bypass", rs_data, 0);
    step();
    iss_rs = 0; #1;
    chk("r0_read", rs_data, 0);
    chk("r0_err_wb", err_wb, 0);
    step();

    // Flush
    issue_wr(1); step();
    issue_wr(3); step();
    chk("fl_pend_before", pend_any, 1);
    flush = 1; wb(3, 9); iss_valid = 1; #1;
    chk("fl_ready", iss_ready, 0);
    step();
    iss_rs = 3; #1;
    chk("fl_pend_any", pend_any, 0);
    chk("fl_err_wb", err_wb, 0);
    chk("fl_reg3", rs_data, 9);
    step();
    wb(1, 11); step();
    iss_rs = 1; #1;
    chk("fl_late_wb_err", err_wb, 1);
    chk("fl_late_wb_data", rs_data, 11);
    step();

    // Reset mid-operation
    issue_wr(5); step();
    rst = 1; #2 rst = 0;
    iss_rs = 4; #1;
    chk("rst2_err_wb", err_wb, 0);
    chk("rst2_pend_any", pend_any, 0);
    chk("rst2_reg4", rs_data, init_val(4));
    step();
    wb(5, 3); step();
    chk("rst2_stale_wb_err", err_wb, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
